// File: rtl/cu_pkg.sv
// ============================================================================
// Module      : cu_pkg
// Description : Shared opcode, FSM state and jump-condition types for the
//               control sequencer and its instruction decoder.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package cu_pkg;

    localparam int c_pc_w_default = 8;

    typedef enum logic [3:0] {
        OP_ALU0 = 4'h0,
        OP_ALU1 = 4'h1,
        OP_ALU2 = 4'h2,
        OP_ALU3 = 4'h3,
        OP_ALU4 = 4'h4,
        OP_ALU5 = 4'h5,
        OP_ALU6 = 4'h6,
        OP_ALU7 = 4'h7,
        OP_ST   = 4'h8,
        OP_CLC  = 4'h9,
        OP_JMP  = 4'hA,
        OP_JC   = 4'hB,
        OP_JNC  = 4'hC,
        OP_NOP0 = 4'hD,
        OP_NOP1 = 4'hE,
        OP_HALT = 4'hF
    } opcode_t;

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_IMM_F  = 3'd3,
        S_IMM_L  = 3'd4,
        S_HALT   = 3'd5
    } state_t;

    typedef enum logic [1:0] {
        JC_ALWAYS = 2'd0,
        JC_IF_CY  = 2'd1,
        JC_IF_NCY = 2'd2
    } jump_cond_t;

endpackage

`default_nettype wire

// File: rtl/cu_decoder.sv
// ============================================================================
// Module      : cu_decoder
// Description : Purely combinational instruction decode, IR -> datapath
//               controls and sequencing hints. Strobes here are ungated.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module cu_decoder
    import cu_pkg::*;
(
    input  logic [7:0]  i_ir,
    output logic [3:0]  o_reg_addr,
    output logic [2:0]  o_alu_code,
    output logic        o_reg_ce,
    output logic        o_cy_ce,
    output logic        o_a_ce,
    output logic        o_cy_clr,
    output logic        o_is_jump,
    output jump_cond_t  o_jump_cond,
    output logic        o_is_halt
);

    opcode_t w_op;

    always_comb begin
        w_op        = opcode_t'(i_ir[7:4]);
        o_reg_addr  = i_ir[3:0];
        o_alu_code  = 3'd0;
        o_reg_ce    = 1'b0;
        o_cy_ce     = 1'b0;
        o_a_ce      = 1'b0;
        o_cy_clr    = 1'b0;
        o_is_jump   = 1'b0;
        o_jump_cond = JC_ALWAYS;
        o_is_halt   = 1'b0;
        case (w_op)
            OP_ALU0, OP_ALU1, OP_ALU2, OP_ALU3,
            OP_ALU4, OP_ALU5, OP_ALU6, OP_ALU7: begin
                o_alu_code = i_ir[6:4];
                o_a_ce     = 1'b1;
                o_cy_ce    = 1'b1;
            end
            OP_ST:   o_reg_ce = 1'b1;
            OP_CLC:  o_cy_clr = 1'b1;
            OP_JMP: begin
                o_is_jump   = 1'b1;
                o_jump_cond = JC_ALWAYS;
            end
            OP_JC: begin
                o_is_jump   = 1'b1;
                o_jump_cond = JC_IF_CY;
            end
            OP_JNC: begin
                o_is_jump   = 1'b1;
                o_jump_cond = JC_IF_NCY;
            end
            OP_HALT: o_is_halt = 1'b1;
            default: ;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/control_sequencer.sv
// ============================================================================
// Module      : control_sequencer
// Description : Fetch/decode/execute controller issuing one-cycle datapath
//               strobes; optional single-step gating via CU_SINGLE_STEP_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module control_sequencer
    import cu_pkg::*;
#(
    parameter int              PC_W     = c_pc_w_default,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            nReset,
    input  logic            run,
`ifdef CU_SINGLE_STEP_EN
    input  logic            step,
`endif
    output logic [PC_W-1:0] pc_addr,
    input  logic [7:0]      instr,
    input  logic            cy_flag,
    output logic [3:0]      RegAddr,
    output logic [2:0]      ALUCode,
    output logic            RegCE,
    output logic            CY_CE,
    output logic            A_CE,
    output logic            cy_clr,
    output logic            halted
);

    localparam logic [PC_W-1:0] c_pc_one = {{(PC_W-1){1'b0}}, 1'b1};

    state_t          r_state;
    state_t          w_state_nxt;
    logic [PC_W-1:0] r_pc;
    logic [PC_W-1:0] w_pc_nxt;
    logic [PC_W-1:0] w_pc_inc;
    logic [PC_W-1:0] w_target;
    logic [7:0]      r_ir;
    logic [7:0]      w_ir_nxt;
    logic            r_taken;
    logic            w_taken_nxt;
    logic            w_go;
    logic            w_exec;

    logic            w_reg_ce;
    logic            w_cy_ce;
    logic            w_a_ce;
    logic            w_cy_clr;
    logic            w_is_jump;
    jump_cond_t      w_jump_cond;
    logic            w_is_halt;

    cu_decoder u_decoder (
        .i_ir        (r_ir),
        .o_reg_addr  (RegAddr),
        .o_alu_code  (ALUCode),
        .o_reg_ce    (w_reg_ce),
        .o_cy_ce     (w_cy_ce),
        .o_a_ce      (w_a_ce),
        .o_cy_clr    (w_cy_clr),
        .o_is_jump   (w_is_jump),
        .o_jump_cond (w_jump_cond),
        .o_is_halt   (w_is_halt)
    );

`ifdef CU_SINGLE_STEP_EN
    assign w_go = run & step;
`else
    assign w_go = run;
`endif

    // Jump target byte is fitted to the PC width: zero-extended or truncated.
    generate
        if (PC_W > 8) begin : g_target_zext
            assign w_target = {{(PC_W-8){1'b0}}, instr};
        end else begin : g_target_trunc
            assign w_target = instr[PC_W-1:0];
        end
    endgenerate

    assign w_pc_inc = r_pc + c_pc_one;

    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        w_ir_nxt    = r_ir;
        w_taken_nxt = r_taken;
        case (r_state)
            S_FETCH: begin
                if (w_go) begin
                    w_state_nxt = S_DECODE;
                end
            end
            S_DECODE: begin
                w_ir_nxt    = instr;
                w_state_nxt = S_EXEC;
            end
            S_EXEC: begin
                if (w_is_halt) begin
                    w_state_nxt = S_HALT;
                end else begin
                    w_pc_nxt = w_pc_inc;
                    if (w_is_jump) begin
                        case (w_jump_cond)
                            JC_IF_CY:  w_taken_nxt = cy_flag;
                            JC_IF_NCY: w_taken_nxt = ~cy_flag;
                            default:   w_taken_nxt = 1'b1;
                        endcase
                        w_state_nxt = S_IMM_F;
                    end else begin
                        w_state_nxt = S_FETCH;
                    end
                end
            end
            S_IMM_F: w_state_nxt = S_IMM_L;
            S_IMM_L: begin
                w_pc_nxt    = r_taken ? w_target : w_pc_inc;
                w_state_nxt = S_FETCH;
            end
            S_HALT:  w_state_nxt = S_HALT;
            default: w_state_nxt = S_FETCH;
        endcase
    end

    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            r_state <= S_FETCH;
            r_pc    <= RESET_PC;
            r_ir    <= 8'h00;
            r_taken <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_pc    <= w_pc_nxt;
            r_ir    <= w_ir_nxt;
            r_taken <= w_taken_nxt;
        end
    end

    // Strobes decode from the state register, so async reset kills them at once.
    assign w_exec  = (r_state == S_EXEC);
    assign RegCE   = w_exec & w_reg_ce;
    assign CY_CE   = w_exec & w_cy_ce;
    assign A_CE    = w_exec & w_a_ce;
    assign cy_clr  = w_exec & w_cy_clr;
    assign halted  = (r_state == S_HALT);
    assign pc_addr = r_pc;

endmodule

`default_nettype wire

// File: tb/tb_control_sequencer.sv
// ============================================================================
// Module      : tb_control_sequencer
// Description : Self-checking bench; instruction-level reference model with
//               randomized programs, stalls and carry values.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_control_sequencer;

    logic       clk = 1'b0;
    always #5 clk = ~clk;

    logic       nReset, run, cy_flag;
    logic [7:0] pc_addr, instr;
    logic [3:0] RegAddr;
    logic [2:0] ALUCode;
    logic       RegCE, CY_CE, A_CE, cy_clr, halted;
    logic [3:0] stb;

    logic       nReset2, run2;
    logic [3:0] pc_addr2;
    logic [7:0] instr2;
    logic [3:0] RegAddr2;
    logic [2:0] ALUCode2;
    logic       RegCE2, CY_CE2, A_CE2, cy_clr2, halted2;
    logic [3:0] stb2;

`ifdef CU_SINGLE_STEP_EN
    logic       step;
    logic       step2 = 1'b1;
`endif

    logic [7:0] mem  [256];
    logic [7:0] mem2 [16];

    int         checks   = 0;
    int         failures = 0;
    logic [7:0] m_pc;

    assign stb  = {RegCE, CY_CE, A_CE, cy_clr};
    assign stb2 = {RegCE2, CY_CE2, A_CE2, cy_clr2};

    always @(posedge clk) begin
        instr  <= mem[pc_addr];
        instr2 <= mem2[pc_addr2];
    end

    control_sequencer #(.PC_W(8), .RESET_PC(8'h00)) dut (
        .clk     (clk),
        .nReset  (nReset),
        .run     (run),
`ifdef CU_SINGLE_STEP_EN
        .step    (step),
`endif
        .pc_addr (pc_addr),
        .instr   (instr),
        .cy_flag (cy_flag),
        .RegAddr (RegAddr),
        .ALUCode (ALUCode),
        .RegCE   (RegCE),
        .CY_CE   (CY_CE),
        .A_CE    (A_CE),
        .cy_clr  (cy_clr),
        .halted  (halted)
    );

    control_sequencer #(.PC_W(4), .RESET_PC(4'hE)) dut2 (
        .clk     (clk),
        .nReset  (nReset2),
        .run     (run2),
`ifdef CU_SINGLE_STEP_EN
        .step    (step2),
`endif
        .pc_addr (pc_addr2),
        .instr   (instr2),
        .cy_flag (1'b0),
        .RegAddr (RegAddr2),
        .ALUCode (ALUCode2),
        .RegCE   (RegCE2),
        .CY_CE   (CY_CE2),
        .A_CE    (A_CE2),
        .cy_clr  (cy_clr2),
        .halted  (halted2)
    );

    task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_idle(input string tag, input logic [7:0] pc);
        check_value({tag, "_pc"}, 32'(pc_addr), 32'(pc));
        check_value({tag, "_stb"}, 32'(stb), 32'h0);
        check_value({tag, "_halted"}, 32'(halted), 32'h0);
    endtask

    task automatic do_reset();
        nReset = 1'b0;
        run    = 1'b0;
        tick();
        tick();
        check_value("rst_pc", 32'(pc_addr), 32'h00);
        check_value("rst_stb", 32'(stb), 32'h0);
        check_value("rst_halted", 32'(halted), 32'h0);
        check_value("rst_regaddr", 32'(RegAddr), 32'h0);
        check_value("rst_alucode", 32'(ALUCode), 32'h0);
        nReset = 1'b1;
        m_pc   = 8'h00;
    endtask

    // One instruction at the model PC: stalls in FETCH, then the architectural
    // cycle sequence with strobes only in the execute cycle.
    task automatic run_instr(input int stalls, input bit cy);
        logic [7:0] b;
        logic [3:0] op;
        logic [3:0] exp_stb;
        logic [7:0] pc1;
        logic [7:0] pc2;
        bit         taken;
        b   = mem[m_pc];
        op  = b[7:4];
        pc1 = m_pc + 8'd1;
        pc2 = m_pc + 8'd2;
        cy_flag = cy;
        run = 1'b0;
        for (int i = 0; i < stalls; i++) begin
            expect_idle("stall", m_pc);
            tick();
        end
        run = 1'b1;
`ifdef CU_SINGLE_STEP_EN
        step = 1'b1;
`endif
        expect_idle("fetch", m_pc);
        tick();
        run = 1'($urandom_range(0, 1));
        expect_idle("decode", m_pc);
        tick();
        if (op < 4'h8)       exp_stb = 4'b0110;
        else if (op == 4'h8) exp_stb = 4'b1000;
        else if (op == 4'h9) exp_stb = 4'b0001;
        else                 exp_stb = 4'b0000;
        check_value("exec_stb", 32'(stb), 32'(exp_stb));
        check_value("exec_pc", 32'(pc_addr), 32'(m_pc));
        check_value("exec_regaddr", 32'(RegAddr), 32'(b[3:0]));
        if (op < 4'h8) check_value("exec_alucode", 32'(ALUCode), 32'(op[2:0]));
        tick();
        if (op == 4'hF) begin
            check_value("halt_halted", 32'(halted), 32'h1);
            check_value("halt_pc", 32'(pc_addr), 32'(m_pc));
            check_value("halt_stb", 32'(stb), 32'h0);
        end else if (op == 4'hA || op == 4'hB || op == 4'hC) begin
            taken = (op == 4'hA) || (op == 4'hB && cy) || (op == 4'hC && !cy);
            expect_idle("imm_f", pc1);
            tick();
            expect_idle("imm_l", pc1);
            tick();
            m_pc = taken ? mem[pc1] : pc2;
        end else begin
            m_pc = pc1;
        end
    endtask

    initial begin
        int a_count;
        nReset  = 1'b0;
        run     = 1'b0;
        cy_flag = 1'b0;
        nReset2 = 1'b0;
        run2    = 1'b0;
`ifdef CU_SINGLE_STEP_EN
        step    = 1'b1;
`endif
        m_pc    = 8'h00;
        for (int i = 0; i < 256; i++) mem[i] = 8'hD0;
        for (int i = 0; i < 16; i++) mem2[i] = 8'hD0;
        mem2[0] = 8'hF0;

        // ALU then store
        do_reset();
        mem[0] = 8'h35;
        mem[1] = 8'h87;
        run_instr(0, 1'b0);
        run_instr(0, 1'b0);
        check_value("alu_st_pc", 32'(pc_addr), 32'h02);

        // JC taken / not taken
        mem[0] = 8'hB0;
        mem[1] = 8'h20;
        do_reset();
        run_instr(0, 1'b1);
        check_value("jc_taken_pc", 32'(pc_addr), 32'h20);
        do_reset();
        run_instr(0, 1'b0);
        check_value("jc_not_taken_pc", 32'(pc_addr), 32'h02);

        // Long run=0 pause in FETCH
        mem[0] = 8'h35;
        do_reset();
        run_instr(10, 1'b0);

        // Async reset in the middle of an ALU execute cycle
        mem[0] = 8'h32;
        do_reset();
        run = 1'b1;
        tick();
        tick();
        check_value("pre_rst_stb", 32'(stb), 32'b0110);
        #2 nReset = 1'b0;
        #1;
        check_value("async_rst_stb", 32'(stb), 32'h0);
        check_value("async_rst_pc", 32'(pc_addr), 32'h00);
        tick();
        check_value("async_rst_regaddr", 32'(RegAddr), 32'h0);
        nReset = 1'b1;
        m_pc   = 8'h00;
        run_instr(2, 1'b0);

        // Randomized program against the reference model
        for (int i = 0; i < 256; i++) begin
            mem[i] = 8'($urandom_range(0, 255));
            if (mem[i][7:4] == 4'hF) mem[i] = {4'hD, mem[i][3:0]};
        end
        do_reset();
        for (int n = 0; n < 150; n++) begin
            run_instr(int'($urandom_range(0, 2)), 1'($urandom_range(0, 1)));
        end

        // HALT freezes the PC until reset
        mem[m_pc] = 8'hF0;
        run_instr(1, 1'b0);
        for (int i = 0; i < 5; i++) begin
            run = 1'($urandom_range(0, 1));
            tick();
            check_value("halt_hold", 32'(halted), 32'h1);
            check_value("halt_hold_pc", 32'(pc_addr), 32'(m_pc));
        end
        do_reset();

        // Narrow PC: NOP at 0xE, NOP at 0xF, wrap to 0, HALT there
        @(posedge clk);
        #1;
        nReset2 = 1'b1;
        run2    = 1'b1;
        for (int c = 0; c < 9; c++) begin
            check_value("w4_pc", 32'(pc_addr2), (c < 3) ? 32'hE : (c < 6) ? 32'hF : 32'h0);
            check_value("w4_stb", 32'(stb2), 32'h0);
            check_value("w4_halted", 32'(halted2), 32'h0);
            tick();
        end
        for (int c = 0; c < 4; c++) begin
            run2 = 1'($urandom_range(0, 1));
            check_value("w4_halt", 32'(halted2), 32'h1);
            check_value("w4_halt_pc", 32'(pc_addr2), 32'h0);
            tick();
        end
        nReset2 = 1'b0;
        #1;
        check_value("w4_rst_halted", 32'(halted2), 32'h0);
        check_value("w4_rst_pc", 32'(pc_addr2), 32'hE);

`ifdef CU_SINGLE_STEP_EN
        // Three step pulses with run held high -> three execute cycles
        for (int i = 0; i < 16; i++) mem[i] = 8'h01;
        do_reset();
        step    = 1'b0;
        run     = 1'b1;
        a_count = 0;
        for (int c = 0; c < 40; c++) begin
            step = (c == 3 || c == 12 || c == 21);
            if (A_CE) a_count++;
            tick();
        end
        check_value("step_exec_count", 32'(a_count), 32'd3);
`else
        a_count = 0;
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
